// File: rtl/hvsp_sequencer_if.sv
// Host command / response and frame-engine handshake bundle for the HVSP sequencer.
interface hvsp_sequencer_if;
    // host side
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_arg;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_status;
    // frame shift engine side
    logic        frm_start;
    logic [7:0]  frm_sdi;
    logic [7:0]  frm_sii;
    logic        frm_busy;
    logic [10:0] frm_sdo;
    logic        sdo_in;

    // sequencer view
    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, frm_busy, frm_sdo, sdo_in,
        output cmd_ready, rsp_valid, rsp_data, rsp_status, frm_start, frm_sdi, frm_sii
    );

    // host + frame engine view
    modport master (
        output cmd_valid, cmd_op, cmd_arg, frm_busy, frm_sdo, sdo_in,
        input  cmd_ready, rsp_valid, rsp_data, rsp_status, frm_start, frm_sdi, frm_sii
    );
endinterface

// File: rtl/hvsp_sequencer.sv
// HVSP command sequencer: expands one host operation into a fixed list of
// SDI/SII frames for the shift engine, then returns SDO data or polls RDY/BSY.
module hvsp_sequencer #(
    parameter int unsigned POLL_TIMEOUT = 60000,
    parameter int unsigned ACK_TIMEOUT  = 15
) (
    input  logic              osc,
    input  logic              rst_n,
    hvsp_sequencer_if.slave   bus
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned ROM_W = 17;

    localparam logic [2:0] OP_READ_SIG   = 3'd1;
    localparam logic [2:0] OP_CHIP_ERASE = 3'd2;
    localparam logic [2:0] OP_READ_FUSE  = 3'd3;
    localparam logic [2:0] OP_WRITE_FUSE = 3'd4;
    localparam logic [2:0] OP_READ_LOCK  = 3'd5;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_BAD_OP  = 2'd1;
    localparam logic [1:0] ST_POLL_TO = 2'd2;
    localparam logic [1:0] ST_NO_ACK  = 2'd3;

    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_NEXT,
        S_POLL,
        S_RESP
    } state_t;

    // Frame ROM keyed by {op, index}: {substitute arg for SDI, SDI, SII}
    function automatic logic [ROM_W-1:0] frame_rom(input logic [5:0] key);
        logic [ROM_W-1:0] v;
        case (key)
            {OP_READ_SIG,   3'd0}: v = {1'b0, 8'h08, 8'h4C};
            {OP_READ_SIG,   3'd1}: v = {1'b1, 8'h00, 8'h0C};
            {OP_READ_SIG,   3'd2}: v = {1'b0, 8'h00, 8'h68};
            {OP_READ_SIG,   3'd3}: v = {1'b0, 8'h00, 8'h6C};
            {OP_CHIP_ERASE, 3'd0}: v = {1'b0, 8'h80, 8'h4C};
            {OP_CHIP_ERASE, 3'd1}: v = {1'b0, 8'h00, 8'h64};
            {OP_CHIP_ERASE, 3'd2}: v = {1'b0, 8'h00, 8'h6C};
            {OP_READ_FUSE,  3'd0}: v = {1'b0, 8'h04, 8'h4C};
            {OP_READ_FUSE,  3'd1}: v = {1'b0, 8'h00, 8'h68};
            {OP_READ_FUSE,  3'd2}: v = {1'b0, 8'h00, 8'h6C};
            {OP_WRITE_FUSE, 3'd0}: v = {1'b0, 8'h40, 8'h4C};
            {OP_WRITE_FUSE, 3'd1}: v = {1'b1, 8'h00, 8'h2C};
            {OP_WRITE_FUSE, 3'd2}: v = {1'b0, 8'h00, 8'h64};
            {OP_WRITE_FUSE, 3'd3}: v = {1'b0, 8'h00, 8'h6C};
            {OP_READ_LOCK,  3'd0}: v = {1'b0, 8'h04, 8'h4C};
            {OP_READ_LOCK,  3'd1}: v = {1'b0, 8'h00, 8'h78};
            {OP_READ_LOCK,  3'd2}: v = {1'b0, 8'h00, 8'h7C};
            default:               v = '0;
        endcase
        return v;
    endfunction

    // Index of the final frame of each operation
    function automatic logic [IDX_W-1:0] last_idx(input logic [2:0] op);
        logic [IDX_W-1:0] v;
        case (op)
            OP_READ_SIG, OP_WRITE_FUSE: v = 3'd3;
            default:                    v = 3'd2;
        endcase
        return v;
    endfunction

    function automatic logic op_is_write(input logic [2:0] op);
        return (op == OP_CHIP_ERASE) || (op == OP_WRITE_FUSE);
    endfunction

    function automatic logic op_is_valid(input logic [2:0] op);
        return (op >= OP_READ_SIG) && (op <= OP_READ_LOCK);
    endfunction

    state_t             r_state;
    logic [2:0]         r_op;
    logic [7:0]         r_arg;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic [7:0]         r_rsp_data;
    logic [1:0]         r_rsp_status;
    logic               r_frm_start;
    logic [7:0]         r_frm_sdi;
    logic [7:0]         r_frm_sii;

    logic [2:0]         w_load_op;
    logic [7:0]         w_load_arg;
    logic [IDX_W-1:0]   w_load_idx;
    logic [ROM_W-1:0]   w_rom;
    logic [7:0]         w_sdi;
    logic [7:0]         w_sii;
    logic               w_unused_sdo;

    // Next frame to load: frame 0 of the incoming command in IDLE, else the following frame
    assign w_load_op    = (r_state == S_IDLE) ? bus.cmd_op  : r_op;
    assign w_load_arg   = (r_state == S_IDLE) ? bus.cmd_arg : r_arg;
    assign w_load_idx   = (r_state == S_IDLE) ? IDX_W'(0)   : IDX_W'(r_idx + IDX_W'(1));
    assign w_rom        = frame_rom({w_load_op, w_load_idx});
    assign w_sdi        = w_rom[16] ? w_load_arg : w_rom[15:8];
    assign w_sii        = w_rom[7:0];
    assign w_unused_sdo = ^{bus.frm_sdo[10], bus.frm_sdo[1:0]};

    // Sequencer FSM with registered outputs
    always_ff @(posedge osc) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_arg        <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_status <= '0;
            r_frm_start  <= 1'b0;
            r_frm_sdi    <= '0;
            r_frm_sii    <= '0;
        end else begin
            r_frm_start <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_cmd_ready) begin
                        r_cmd_ready <= 1'b1;
                    end else if (bus.cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= bus.cmd_op;
                        r_arg       <= bus.cmd_arg;
                        r_idx       <= '0;
                        if (op_is_valid(bus.cmd_op)) begin
                            r_frm_sdi   <= w_sdi;
                            r_frm_sii   <= w_sii;
                            r_frm_start <= 1'b1;
                            r_state     <= S_ISSUE;
                        end else begin
                            r_rsp_data   <= '0;
                            r_rsp_status <= ST_BAD_OP;
                            r_state      <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (bus.frm_busy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_cnt >= ACK_LAST) begin
                        r_rsp_data   <= '0;
                        r_rsp_status <= ST_NO_ACK;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.frm_busy) begin
                        r_state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (r_idx != last_idx(r_op)) begin
                        r_idx       <= w_load_idx;
                        r_frm_sdi   <= w_sdi;
                        r_frm_sii   <= w_sii;
                        r_frm_start <= 1'b1;
                        r_state     <= S_ISSUE;
                    end else if (op_is_write(r_op)) begin
                        r_cnt   <= '0;
                        r_state <= S_POLL;
                    end else begin
                        r_rsp_data   <= bus.frm_sdo[9:2];
                        r_rsp_status <= ST_OK;
                        r_state      <= S_RESP;
                    end
                end
                S_POLL: begin
                    if (bus.sdo_in) begin
                        r_rsp_data   <= '0;
                        r_rsp_status <= ST_OK;
                        r_state      <= S_RESP;
                    end else if (r_cnt >= POLL_LAST) begin
                        r_rsp_data   <= '0;
                        r_rsp_status <= ST_POLL_TO;
                        r_state      <= S_RESP;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_status = r_rsp_status;
    assign bus.frm_start  = r_frm_start;
    assign bus.frm_sdi    = r_frm_sdi;
    assign bus.frm_sii    = r_frm_sii;

endmodule

// File: tb/tb_hvsp_sequencer.sv
// Directed bench for hvsp_sequencer with a fixed-latency frame engine model.
module tb_hvsp_sequencer;

    localparam int unsigned PT = 1000;
    localparam int unsigned AT = 15;
    localparam int          B  = 44;
    localparam int          FR = B + 3;

    logic osc = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    hvsp_sequencer_if bus ();

    hvsp_sequencer #(.POLL_TIMEOUT(PT), .ACK_TIMEOUT(AT)) u_dut (
        .osc   (osc),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 osc = ~osc;
    always @(posedge osc) cyc <= cyc + 1;

    // frame engine model: busy for B cycles after a sampled start
    bit eng_en = 1'b1;
    int eng_cnt = 0;
    always @(posedge osc) begin
        if (eng_en && bus.frm_start) eng_cnt <= B;
        else if (eng_cnt > 0)        eng_cnt <= eng_cnt - 1;
    end
    assign bus.frm_busy = (eng_cnt != 0);

    // record frames and responses
    logic [15:0] frm_q[$];
    int          frm_t[$];
    int          rsp_cnt = 0;
    always @(negedge osc) begin
        if (bus.frm_start === 1'b1) begin
            frm_q.push_back({bus.frm_sdi, bus.frm_sii});
            frm_t.push_back(cyc);
        end
        if (bus.rsp_valid === 1'b1) rsp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] arg, output int t);
        int g;
        g = 0;
        while (bus.cmd_ready !== 1'b1 && g < 5000) begin
            @(negedge osc);
            g++;
        end
        if (g >= 5000) begin
            n_chk++;
            $display("FAIL send_ready: cmd_ready stayed low for %0d cycles", g);
        end
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        bus.cmd_valid = 1'b1;
        t = cyc;
        @(negedge osc);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int t, output logic [7:0] d, output logic [1:0] s);
        t = -1;
        d = '0;
        s = '0;
        for (int i = 0; i < budget; i++) begin
            if (bus.rsp_valid === 1'b1) begin
                t = cyc;
                d = bus.rsp_data;
                s = bus.rsp_status;
                break;
            end
            @(negedge osc);
        end
        if (t < 0) begin
            n_chk++;
            $display("FAIL rsp_wait: no rsp_valid within %0d cycles", budget);
        end
    endtask

    task automatic check_frames(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3, input int n);
        logic [15:0] ex[4];
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        check({tag, "_nfrm"}, frm_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < frm_q.size()) check($sformatf("%s_frm%0d", tag, i), frm_q[i], ex[i]);
        end
    endtask

    int          t, tr, base;
    logic [7:0]  d;
    logic [1:0]  s;

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_arg   = '0;
        bus.frm_sdo   = '0;
        bus.sdo_in    = 1'b0;

        // reset state
        repeat (3) @(negedge osc);
        check("rst_ready", bus.cmd_ready, 0);
        check("rst_outs", {bus.frm_start, bus.frm_sdi, bus.frm_sii, bus.rsp_valid,
                           bus.rsp_data, bus.rsp_status}, 0);
        rst_n = 1'b1;
        @(negedge osc);
        check("rst_ready_up", bus.cmd_ready, 1);

        // READ_SIG arg=01
        frm_q.delete(); frm_t.delete();
        bus.frm_sdo = 11'b0_10010000_00;
        send(3'd1, 8'h01, t);
        wait_rsp(1000, tr, d, s);
        check_frames("rsig", 16'h084C, 16'h010C, 16'h0068, 16'h006C, 4);
        if (frm_t.size() >= 2) begin
            check("rsig_first_start", frm_t[0], t + 1);
            check("rsig_frame_period", frm_t[1] - frm_t[0], FR);
        end
        check("rsig_lat", tr, t + 4 * FR + 2);
        check("rsig_data", d, 8'h90);
        check("rsig_status", s, 0);
        @(negedge osc);
        check("rsig_pulse_ready", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
        check("rsig_data_held", bus.rsp_data, 8'h90);

        // READ_LOCK with reset during WAIT_DONE
        repeat (5) @(negedge osc);
        frm_q.delete(); frm_t.delete();
        base = rsp_cnt;
        send(3'd5, 8'h00, t);
        while (cyc < t + 10) @(negedge osc);
        rst_n = 1'b0;
        @(negedge osc);
        rst_n = 1'b1;
        check("mrst_outs", {bus.cmd_ready, bus.frm_start, bus.frm_sdi, bus.frm_sii,
                            bus.rsp_valid, bus.rsp_data, bus.rsp_status}, 0);
        @(negedge osc);
        check("mrst_ready", bus.cmd_ready, 1);
        repeat (200) @(negedge osc);
        check("mrst_no_rsp", rsp_cnt - base, 0);
        check("mrst_nfrm", frm_q.size(), 1);

        // CHIP_ERASE, RDY 500 cycles after last frame
        frm_q.delete(); frm_t.delete();
        send(3'd2, 8'h00, t);
        while (cyc < t + 3 * FR + 500) @(negedge osc);
        bus.sdo_in = 1'b1;
        wait_rsp(100, tr, d, s);
        bus.sdo_in = 1'b0;
        check_frames("cerase", 16'h804C, 16'h0064, 16'h006C, 16'h0000, 3);
        check("cerase_lat", tr, t + 3 * FR + 502);
        check("cerase_status", s, 0);
        check("cerase_data", d, 0);

        // WRITE_FUSE_LO arg=6A, RDY never rises
        repeat (3) @(negedge osc);
        frm_q.delete(); frm_t.delete();
        send(3'd4, 8'h6A, t);
        wait_rsp(4 * FR + PT + 100, tr, d, s);
        check_frames("wfuse", 16'h404C, 16'h6A2C, 16'h0064, 16'h006C, 4);
        check("wfuse_lat", tr, t + 4 * FR + 2 + PT);
        check("wfuse_status", s, 2);
        check("wfuse_data", d, 0);

        // bad opcode 7
        repeat (3) @(negedge osc);
        frm_q.delete(); frm_t.delete();
        send(3'd7, 8'h55, t);
        wait_rsp(20, tr, d, s);
        check("bad7_lat", tr, t + 2);
        check("bad7_status", s, 1);
        check("bad7_data", d, 0);
        @(negedge osc);
        check("bad7_ready", bus.cmd_ready, 1);
        check("bad7_nfrm", frm_q.size(), 0);

        // bad opcode 0
        send(3'd0, 8'h00, t);
        wait_rsp(20, tr, d, s);
        check("bad0_lat", tr, t + 2);
        check("bad0_status", s, 1);

        // engine never acknowledges; cmd_valid held during the wait
        repeat (3) @(negedge osc);
        eng_en = 1'b0;
        frm_q.delete(); frm_t.delete();
        base = rsp_cnt;
        send(3'd3, 8'h00, t);
        bus.cmd_op    = 3'd1;
        bus.cmd_valid = 1'b1;
        tr = -1;
        for (int i = 0; i < 100; i++) begin
            if (bus.rsp_valid === 1'b1) begin
                tr = cyc;
                s  = bus.rsp_status;
                d  = bus.rsp_data;
                break;
            end
            @(negedge osc);
        end
        bus.cmd_valid = 1'b0;
        check("noack_lat", tr, t + 3 + AT);
        check("noack_status", s, 3);
        check("noack_data", d, 0);
        repeat (100) @(negedge osc);
        check("noack_one_rsp", rsp_cnt - base, 1);
        check("noack_nfrm", frm_q.size(), 1);
        eng_en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hvsp_sequencer.md
# hvsp_sequencer

Serial high-voltage programming (HVSP) command sequencer for 8-pin AVR targets. It accepts one high-level operation at a time from the host-side register file, such as read signature, chip erase or fuse write. For each operation it issues the fixed series of 11-bit SDI/SII frames to the existing frame shift engine. It then either returns the SDO payload of the final frame or polls the target's SDO RDY/BSY line until the write completes. It sits between the host register decode and the frame shift engine that drives the ZIF pins.

## Interface
Parameters:
- POLL_TIMEOUT, 60000: max cycles waiting for SDO high after a write/erase (5 ms at 12 MHz).
- ACK_TIMEOUT, 15: max cycles waiting for frm_busy to rise after frm_start.

Ports:
- osc  in  1  12 MHz clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  host presents an operation.
- cmd_ready  out  1  high only in IDLE; a command is accepted on cmd_valid & cmd_ready.
- cmd_op  in  3  operation code, sampled at accept.
- cmd_arg  in  8  address or data byte, sampled at accept.
- rsp_valid  out  1  one-cycle pulse when the operation finishes.
- rsp_data  out  8  result byte; valid with rsp_valid, held until the next accept.
- rsp_status  out  2  0 ok, 1 bad opcode, 2 poll timeout, 3 engine no-ack; held like rsp_data.
- frm_start  out  1  one-cycle pulse requesting one frame.
- frm_sdi  out  8  SDI payload; stable from frm_start until the frame is done.
- frm_sii  out  8  SII payload; same stability rule as frm_sdi.
- frm_busy  in  1  frame engine busy flag.
- frm_sdo  in  11  captured SDO bits of the last frame, MSB first; valid when frm_busy is low.
- sdo_in  in  1  live SDO pin level, used for RDY polling.

## Operation
Each operation is a fixed frame list, written as (SDI, SII):
- 1 READ_SIG: (08,4C), (arg,0C), (00,68), (00,6C). Result is sdo[9:2] of the last frame.
- 2 CHIP_ERASE: (80,4C), (00,64), (00,6C), then poll.
- 3 READ_FUSE_LO: (04,4C), (00,68), (00,6C). Result from the last frame.
- 4 WRITE_FUSE_LO: (40,4C), (arg,2C), (00,64), (00,6C), then poll.
- 5 READ_LOCK: (04,4C), (00,78), (00,7C). Result from the last frame.
- 0, 6, 7: no frames issued; rsp_status=1 and rsp_data=0.

Frame lists are held in a ROM indexed by {op, frame index}. The frame index is 3 bits wide and resets to 0 at accept.

State machine:
- IDLE: cmd_ready=1. On accept, latch op and arg, then go to ISSUE. A bad opcode goes to RESP with status 1.
- ISSUE: drive frm_sdi/frm_sii, pulse frm_start, go to WAIT_ACK.
- WAIT_ACK: when frm_busy=1, go to WAIT_DONE. After ACK_TIMEOUT cycles without frm_busy, go to RESP with status 3.
- WAIT_DONE: when frm_busy=0, go to NEXT.
- NEXT: if frames remain, increment the index and go to ISSUE.
  - For a read op, latch rsp_data=frm_sdo[9:2] and go to RESP.
  - For a write op, clear the timeout counter and go to POLL.
- POLL: when sdo_in=1, go to RESP with status 0. When the counter reaches POLL_TIMEOUT, go to RESP with status 2. rsp_data=0 for write ops.
- RESP: pulse rsp_valid, go to IDLE.

Width and boundary rules:
- The poll counter is 16 bits and saturates; it never wraps.
- cmd_valid outside IDLE is ignored; it is not queued.
- A frm_busy glitch back to 1 during NEXT is ignored.
- Reset at any state returns to IDLE on the next edge. Reset also clears frm_start, frm_sdi, frm_sii, rsp_valid, rsp_data and rsp_status to 0. An in-flight engine frame is not aborted by this block.

## Timing
- Reset values: cmd_ready=0 during reset, 1 on the first cycle after rst_n rises. All other outputs are 0.
- Accept cycle N: frm_start is high at N+1.
- With an engine busy time of B cycles, each frame costs B+3 cycles: ISSUE, WAIT_ACK entry, B busy cycles, NEXT.
- rsp_valid is high exactly one cycle, one cycle after the final NEXT or POLL exit. cmd_ready is high the cycle after that.
- Bad opcode: rsp_valid at N+2.
- frm_sdi/frm_sii change only in ISSUE.

## Test plan
- READ_SIG arg=01, engine model B=44, last frm_sdo=11'b0_10010000_00 -> four frames with exact (SDI,SII) pairs; rsp_data=0x90, status 0, latency 4·47+2 cycles.
- CHIP_ERASE, sdo_in rises 500 cycles after the last frame -> three frames then poll; rsp_valid 501–502 cycles later with status 0.
- WRITE_FUSE_LO arg=6A, sdo_in held low -> second frame SDI=0x6A; status 2 after exactly POLL_TIMEOUT poll cycles.
- cmd_op=7 -> no frm_start; rsp_valid at accept+2, status 1, rsp_data 0.
- Engine never raises frm_busy -> status 3 after ACK_TIMEOUT cycles; cmd_valid during the wait is ignored and no second response appears.
- rst_n low for 1 cycle during WAIT_DONE of READ_LOCK -> all outputs 0, cmd_ready=1 the next cycle, and no rsp_valid for the aborted op.
